// File: rtl/shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-add multiplier: SIZE x SIZE -> 2*SIZE product.
// Latency SIZE+1 edges (1 edge for a zero operand); start is ignored while a multiply is running.

module shift_add_multiplier_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic zero_op,
  input  logic last_step,
  output logic load,
  output logic load_zero,
  output logic step,
  output logic finish,
  output logic done
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic accept;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load      = 1'b0;
    load_zero = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        accept = start;
        if (start) begin
          load      = !zero_op;
          load_zero = zero_op;
          state_d   = zero_op ? DONE : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last_step) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done comes straight off the state register, so no input reaches it combinationally
  assign done = (state_q == DONE);
endmodule

module shift_add_multiplier_dp #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] multiplicand,
  input  logic [SIZE-1:0] multiplier,
  input  logic            load,
  input  logic            load_zero,
  input  logic            step,
  input  logic            finish,
  output logic            zero_op,
  output logic            last_step,
  output logic            overflow,
  output logic [SIZE-1:0] product_hi,
  output logic [SIZE-1:0] product_lo
);
  localparam int CW = $clog2(SIZE + 1);

  logic [SIZE-1:0] mcand_q, acc_q, mplier_q;
  logic [CW-1:0]   cnt_q;
  logic [SIZE:0]   sum;
  logic [SIZE-1:0] acc_d, mplier_d;

  assign zero_op   = (multiplicand == '0) || (multiplier == '0);
  assign last_step = (cnt_q == CW'(1));

  // The carry out of the add lands in the accumulator MSB after the shift.
  always_comb begin
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(SIZE+1){1'b0}});
    acc_d    = sum[SIZE:1];
    mplier_d = {sum[0], mplier_q[SIZE-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_q    <= '0;
      acc_q      <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      overflow   <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      if (load) begin
        mcand_q  <= multiplicand;
        mplier_q <= multiplier;
        acc_q    <= '0;
        cnt_q    <= CW'(SIZE);
      end else if (step) begin
        acc_q    <= acc_d;
        mplier_q <= mplier_d;
        cnt_q    <= cnt_q - CW'(1);
      end
      if (load_zero) begin
        product_hi <= '0;
        product_lo <= '0;
        overflow   <= 1'b0;
      end else if (finish) begin
        product_hi <= acc_d;
        product_lo <= mplier_d;
        overflow   <= (acc_d != '0);
      end
    end
  end
endmodule

module shift_add_multiplier #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] multiplicand,
  input  logic [SIZE-1:0] multiplier,
  output logic            done,
  output logic            overflow,
  output logic [SIZE-1:0] product_hi,
  output logic [SIZE-1:0] product_lo
);
  logic zero_op, last_step, load, load_zero, step, finish;

  shift_add_multiplier_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .zero_op   (zero_op),
    .last_step (last_step),
    .load      (load),
    .load_zero (load_zero),
    .step      (step),
    .finish    (finish),
    .done      (done)
  );

  shift_add_multiplier_dp #(.SIZE(SIZE)) u_dp (
    .clk          (clk),
    .reset        (reset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .load         (load),
    .load_zero    (load_zero),
    .step         (step),
    .finish       (finish),
    .zero_op      (zero_op),
    .last_step    (last_step),
    .overflow     (overflow),
    .product_hi   (product_hi),
    .product_lo   (product_lo)
  );
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed-vector bench for shift_add_multiplier at SIZE = 32.
module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        done, overflow;
  logic [31:0] product_hi, product_lo;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  shift_add_multiplier #(.SIZE(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .done         (done),
    .overflow     (overflow),
    .product_hi   (product_hi),
    .product_lo   (product_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives start for one edge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat counts rising edges including the accepting one; called at the negedge after it.
  task automatic wait_done(inout int lat);
    while (!done && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_result(input string name, input int lat, input vec_t v);
    chk({name, "_lat"}, 64'(lat), 64'(v.lat));
    chk({name, "_done"}, {63'b0, done}, 64'd1);
    chk({name, "_prod"}, {product_hi, product_lo}, {v.hi, v.lo});
    chk({name, "_ovf"}, {63'b0, overflow}, {63'b0, v.ovf});
  endtask

  initial begin
    int   lat;
    vec_t v;

    vecs[0] = '{32'd7,        32'd6,        32'h0,        32'd42,       1'b0, 33};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 33};
    vecs[2] = '{32'h0,        32'h1234,     32'h0,        32'h0,        1'b0, 1};
    vecs[3] = '{32'h00010000, 32'h00010000, 32'h1,        32'h0,        1'b1, 33};
    vecs[4] = '{32'd1,        32'd1,        32'h0,        32'd1,        1'b0, 33};
    vecs[5] = '{32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, 1'b0, 33};
    vecs[6] = '{32'h80000000, 32'd2,        32'h1,        32'h0,        1'b1, 33};
    vecs[7] = '{32'h1234,     32'h0,        32'h0,        32'h0,        1'b0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_prod", {product_hi, product_lo}, 64'd0);
    chk("rst_ovf", {63'b0, overflow}, 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      lat = 1;
      wait_done(lat);
      chk_result($sformatf("vec%0d", i), lat, vecs[i]);
    end

    // Reset aborts a running multiply on the 10th CALC edge
    start_op(32'd5, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_prod", {product_hi, product_lo}, 64'd0);
    chk("abort_ovf", {63'b0, overflow}, 64'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    chk("abort_idle", {63'b0, done}, 64'd0);
    start_op(32'd3, 32'd4);
    lat = 1;
    wait_done(lat);
    v = '{32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33};
    chk_result("after_rst", lat, v);

    // Start held with new operands during CALC must be ignored
    start_op(32'd9, 32'd9);
    lat = 1;
    start = 1'b1;
    multiplicand = 32'd2;
    multiplier = 32'd2;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("calc_hold_lo", {32'b0, product_lo}, 64'd12);
    wait_done(lat);
    v = '{32'd9, 32'd9, 32'h0, 32'd81, 1'b0, 33};
    chk_result("ignored", lat, v);

    // Back-to-back from DONE; old result held while the new one computes
    start_op(32'd2, 32'd2);
    chk("b2b_drop", {63'b0, done}, 64'd0);
    chk("b2b_hold", {32'b0, product_lo}, 64'd81);
    lat = 1;
    wait_done(lat);
    v = '{32'd2, 32'd2, 32'h0, 32'd4, 1'b0, 33};
    chk_result("b2b", lat, v);

    // DONE persists with start low
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("done_rest", {63'b0, done}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
